waveform_dm_cmd_gen: RTL

- Command/status sequencer directly upstream of the waveform BRAM datamover stage.
- Turns simple load/playback requests (address, byte count) into 72-bit DataMover S2MM/MM2S command beats.
- Consumes the 8-bit status streams and reports done/error per direction.
- S2MM (waveform load into BRAM) and MM2S (waveform playback) channels run independently; each has one command outstanding.

---
 rtl/waveform_dm_pkg.sv | 66 ++++++
 rtl/waveform_dm_channel.sv | 126 ++++++++++++
 rtl/waveform_dm_cmd_gen.sv | 95 +++++++++
 3 files changed

// File: rtl/waveform_dm_pkg.sv
// ---------------------------------------------------------------------------
// waveform_dm_pkg
// Shared field offsets, status bits, error codes and FSM states for the
// waveform BRAM datamover command generator.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package waveform_dm_pkg;

   localparam int CMD_W          = 72;
   localparam int CMD_BTT_LSB    = 0;
   localparam int CMD_BTT_W      = 23;
   localparam int CMD_TYPE_BIT   = 23;
   localparam int CMD_DSA_LSB    = 24;
   localparam int CMD_EOF_BIT    = 30;
   localparam int CMD_DRR_BIT    = 31;
   localparam int CMD_SADDR_LSB  = 32;
   localparam int CMD_TAG_LSB    = 64;
   localparam int TAG_W          = 4;
   localparam int STS_W          = 8;

   localparam int STS_OKAY       = 7;
   localparam int STS_SLVERR     = 6;
   localparam int STS_DECERR     = 5;
   localparam int STS_INTERR     = 4;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_REJECT  = 2'd1;
   localparam logic [1:0] ERR_STATUS  = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CMD      = 2'd1,
      ST_WAIT_STS = 2'd2
   } dm_state_t;

   function automatic logic [CMD_W-1:0] build_cmd(
      input logic [31:0]          saddr,
      input logic [CMD_BTT_W-1:0] btt,
      input logic [TAG_W-1:0]     tag
   );
      logic [CMD_W-1:0] cmd;
      cmd = '0;
      cmd[CMD_BTT_LSB +: CMD_BTT_W] = btt;
      cmd[CMD_TYPE_BIT]             = 1'b1;
      cmd[CMD_EOF_BIT]              = 1'b1;
      cmd[CMD_SADDR_LSB +: 32]      = saddr;
      cmd[CMD_TAG_LSB +: TAG_W]     = tag;
      return cmd;
   endfunction

   // A status beat is bad if OKAY is missing, any error flag is set,
   // or it echoes a tag other than the one issued.
   function automatic logic sts_is_error(
      input logic [STS_W-1:0] sts,
      input logic [TAG_W-1:0] tag
   );
      return !sts[STS_OKAY] || sts[STS_SLVERR] || sts[STS_DECERR] ||
             sts[STS_INTERR] || (sts[TAG_W-1:0] != tag);
   endfunction

endpackage

`default_nettype wire

// File: rtl/waveform_dm_channel.sv
// ---------------------------------------------------------------------------
// waveform_dm_channel
// One command/status sequencer: issues a single datamover command, waits for
// its status beat (or a watchdog timeout) and reports done/error.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module waveform_dm_channel
   import waveform_dm_pkg::*;
#(
   parameter int ADDR_WIDTH     = 18,
   parameter int TIMEOUT_CYCLES = 65536,
   parameter int TIMER_WIDTH    = 17
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [CMD_BTT_W-1:0]  i_len,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_err,
   output logic [1:0]            o_err_code,
   output logic [STS_W-1:0]      o_sts,
   output logic [CMD_W-1:0]      o_cmd_tdata,
   output logic                  o_cmd_tvalid,
   input  logic                  i_cmd_tready,
   input  logic [STS_W-1:0]      i_sts_tdata,
   input  logic                  i_sts_tvalid,
   output logic                  o_sts_tready
);

   localparam logic [TIMER_WIDTH-1:0] c_TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

   dm_state_t              r_state;
   logic [TAG_W-1:0]       r_tag_cnt;
   logic [TAG_W-1:0]       r_tag;
   logic [CMD_W-1:0]       r_cmd;
   logic                   r_cmd_valid;
   logic                   r_done;
   logic                   r_err;
   logic [1:0]             r_err_code;
   logic [STS_W-1:0]       r_sts;
   logic [TIMER_WIDTH-1:0] r_timer;

   logic w_reject;
   logic w_timeout;

   assign w_reject  = (i_len == '0) || (i_addr[1:0] != 2'b00);
   assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_timer == c_TIMER_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_tag_cnt   <= '0;
         r_tag       <= '0;
         r_cmd       <= '0;
         r_cmd_valid <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_err_code  <= ERR_NONE;
         r_sts       <= '0;
         r_timer     <= '0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_req) begin
                  if (w_reject) begin
                     r_err      <= 1'b1;
                     r_err_code <= ERR_REJECT;
                  end else begin
                     r_cmd       <= build_cmd(32'(i_addr), i_len, r_tag_cnt);
                     r_cmd_valid <= 1'b1;
                     r_tag       <= r_tag_cnt;
                     r_err_code  <= ERR_NONE;
                     r_state     <= ST_CMD;
                  end
               end
            end
            ST_CMD: begin
               if (i_cmd_tready) begin
                  r_cmd_valid <= 1'b0;
                  r_tag_cnt   <= r_tag_cnt + 1'b1;
                  r_timer     <= '0;
                  r_state     <= ST_WAIT_STS;
               end
            end
            ST_WAIT_STS: begin
               // A status beat on the timeout cycle wins over the watchdog.
               if (i_sts_tvalid) begin
                  r_sts   <= i_sts_tdata;
                  r_state <= ST_IDLE;
                  if (sts_is_error(i_sts_tdata, r_tag)) begin
                     r_err      <= 1'b1;
                     r_err_code <= ERR_STATUS;
                  end else begin
                     r_done <= 1'b1;
                  end
               end else if (w_timeout) begin
                  r_err      <= 1'b1;
                  r_err_code <= ERR_TIMEOUT;
                  r_state    <= ST_IDLE;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_busy       = (r_state != ST_IDLE);
   assign o_sts_tready = (r_state == ST_WAIT_STS);
   assign o_done       = r_done;
   assign o_err        = r_err;
   assign o_err_code   = r_err_code;
   assign o_sts        = r_sts;
   assign o_cmd_tdata  = r_cmd;
   assign o_cmd_tvalid = r_cmd_valid;

endmodule

`default_nettype wire

// File: rtl/waveform_dm_cmd_gen.sv
// ---------------------------------------------------------------------------
// waveform_dm_cmd_gen
// Independent S2MM (load) and MM2S (playback) command/status sequencers.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module waveform_dm_cmd_gen
   import waveform_dm_pkg::*;
#(
   parameter int ADDR_WIDTH     = 18,
   parameter int TIMEOUT_CYCLES = 65536,
   parameter int TIMER_WIDTH    = 17
) (
   input  logic                  clk_in1,
   input  logic                  reset,
   input  logic                  wr_req,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [22:0]           wr_len,
   output logic                  wr_busy,
   output logic                  wr_done,
   output logic                  wr_err,
   output logic [1:0]            wr_err_code,
   output logic [7:0]            wr_sts,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [22:0]           rd_len,
   output logic                  rd_busy,
   output logic                  rd_done,
   output logic                  rd_err,
   output logic [1:0]            rd_err_code,
   output logic [7:0]            rd_sts,
   output logic [71:0]           s_axis_s2mm_cmd_tdata,
   output logic                  s_axis_s2mm_cmd_tvalid,
   input  logic                  s_axis_s2mm_cmd_tready,
   input  logic [7:0]            m_axis_s2mm_sts_tdata,
   input  logic                  m_axis_s2mm_sts_tvalid,
   output logic                  m_axis_s2mm_sts_tready,
   output logic [71:0]           s_axis_mm2s_cmd_tdata,
   output logic                  s_axis_mm2s_cmd_tvalid,
   input  logic                  s_axis_mm2s_cmd_tready,
   input  logic [7:0]            m_axis_mm2s_sts_tdata,
   input  logic                  m_axis_mm2s_sts_tvalid,
   output logic                  m_axis_mm2s_sts_tready
);

   waveform_dm_channel #(
      .ADDR_WIDTH     (ADDR_WIDTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TIMER_WIDTH    (TIMER_WIDTH)
   ) u_s2mm (
      .clk          (clk_in1),
      .rst          (reset),
      .i_req        (wr_req),
      .i_addr       (wr_addr),
      .i_len        (wr_len),
      .o_busy       (wr_busy),
      .o_done       (wr_done),
      .o_err        (wr_err),
      .o_err_code   (wr_err_code),
      .o_sts        (wr_sts),
      .o_cmd_tdata  (s_axis_s2mm_cmd_tdata),
      .o_cmd_tvalid (s_axis_s2mm_cmd_tvalid),
      .i_cmd_tready (s_axis_s2mm_cmd_tready),
      .i_sts_tdata  (m_axis_s2mm_sts_tdata),
      .i_sts_tvalid (m_axis_s2mm_sts_tvalid),
      .o_sts_tready (m_axis_s2mm_sts_tready)
   );

   waveform_dm_channel #(
      .ADDR_WIDTH     (ADDR_WIDTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TIMER_WIDTH    (TIMER_WIDTH)
   ) u_mm2s (
      .clk          (clk_in1),
      .rst          (reset),
      .i_req        (rd_req),
      .i_addr       (rd_addr),
      .i_len        (rd_len),
      .o_busy       (rd_busy),
      .o_done       (rd_done),
      .o_err        (rd_err),
      .o_err_code   (rd_err_code),
      .o_sts        (rd_sts),
      .o_cmd_tdata  (s_axis_mm2s_cmd_tdata),
      .o_cmd_tvalid (s_axis_mm2s_cmd_tvalid),
      .i_cmd_tready (s_axis_mm2s_cmd_tready),
      .i_sts_tdata  (m_axis_mm2s_sts_tdata),
      .i_sts_tvalid (m_axis_mm2s_sts_tvalid),
      .o_sts_tready (m_axis_mm2s_sts_tready)
   );

endmodule

`default_nettype wire
